// File: rtl/gruel_pkg.sv
// rtl/gruel_pkg.sv - shared states, coin values and default pricing for the gruel vend controller
package gruel_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  localparam int COIN1_VAL               = 1;
  localparam int COIN2_VAL               = 2;
  localparam int DEFAULT_CREDIT_W        = 4;
  localparam int DEFAULT_PRICE           = 4;
  localparam int DEFAULT_MAX_CREDIT      = 8;
  localparam int DEFAULT_DISPENSE_CYCLES = 3;

endpackage

// File: rtl/gruel_dispense_timer.sv
// rtl/gruel_dispense_timer.sv - loadable down-counter timing the dispense strobe
module gruel_dispense_timer
  import gruel_pkg::*;
#(
  parameter int CYCLES = DEFAULT_DISPENSE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CNT_W'(CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Done marks the last strobe cycle so the controller leaves DISPENSE on the following edge.
  assign done = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gruel_vend_ctrl.sv
// rtl/gruel_vend_ctrl.sv - coin collection, vend and change-payout controller for the gruel machine
module gruel_vend_ctrl
  import gruel_pkg::*;
#(
  parameter int CREDIT_W        = DEFAULT_CREDIT_W,
  parameter int MAX_CREDIT      = DEFAULT_MAX_CREDIT,
  parameter int PRICE           = DEFAULT_PRICE,
  parameter int DISPENSE_CYCLES = DEFAULT_DISPENSE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_1,
  input  logic                coin_2,
  input  logic                vend_req,
  input  logic                cancel,
  input  logic                gruel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                vend_denied,
  output logic                busy
);

  localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W + 1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_W   = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                change_pulse_q, change_pulse_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_denied_q, vend_denied_d;
  logic                busy_q, busy_d;

  logic                timer_start;
  logic                timer_done;
  logic [CREDIT_W:0]   credit_w;
  logic [CREDIT_W:0]   add_w;
  logic [CREDIT_W:0]   sum_w;
  logic                any_coin;

  gruel_dispense_timer #(
    .CYCLES (DISPENSE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (timer_start),
    .done  (timer_done)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    coin_reject_d = 1'b0;
    vend_denied_d = 1'b0;
    timer_start   = 1'b0;

    any_coin = coin_1 | coin_2;
    credit_w = {1'b0, credit_q};
    add_w    = '0;
    if (coin_1) add_w = add_w + (CREDIT_W + 1)'(COIN1_VAL);
    if (coin_2) add_w = add_w + (CREDIT_W + 1)'(COIN2_VAL);
    sum_w = credit_w + add_w;

    case (state_q)
      IDLE: begin
        if (cancel && credit_q != '0) begin
          state_d       = CHANGE;
          coin_reject_d = any_coin;
        end else if (vend_req && gruel && credit_w >= PRICE_W) begin
          // The local range check keeps credit from wrapping even if the decoder flag is wrong.
          credit_d      = CREDIT_W'(credit_w - PRICE_W);
          state_d       = DISPENSE;
          timer_start   = 1'b1;
          coin_reject_d = any_coin;
        end else begin
          vend_denied_d = vend_req;
          if (any_coin) begin
            if (sum_w <= MAX_W) begin
              credit_d = sum_w[CREDIT_W-1:0];
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = any_coin;
        if (timer_done) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = any_coin;
        if (credit_q != '0) begin
          credit_d = credit_q - CREDIT_W'(1);
        end
        if (credit_q <= CREDIT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes follow the next state so they line up with the registered state.
    dispense_d     = (state_d == DISPENSE);
    change_pulse_d = (state_d == CHANGE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      change_pulse_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      vend_denied_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      change_pulse_q <= change_pulse_d;
      coin_reject_q  <= coin_reject_d;
      vend_denied_q  <= vend_denied_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign change_pulse = change_pulse_q;
  assign coin_reject  = coin_reject_q;
  assign vend_denied  = vend_denied_q;
  assign busy         = busy_q;

endmodule
